// File: rtl/scn_pkg.sv
// rtl/scn_pkg.sv - shared types, field positions and widths for the tilemap layer fetch
package scn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROWSCROLL,
        ST_ATTR,
        ST_CODE,
        ST_ROM,
        ST_WRITE,
        ST_DONE
    } scn_state_e;

    localparam int COLOR_MSB = 7;
    localparam int FLIPX_BIT = 14;
    localparam int FLIPY_BIT = 15;
    localparam int TILE_W    = 8;
    localparam int DOT_W     = 4;
    localparam int PIX_W     = COLOR_MSB + 1 + DOT_W;
    localparam int RAM_AW    = 16;
    localparam int RAM_DW    = 16;
    localparam int ROM_AW    = 21;
    localparam int ROM_DW    = 32;

    // Leftmost dot sits in the top nibble; flipx walks the row from the other end.
    function automatic logic [DOT_W-1:0] tile_dot(input logic [ROM_DW-1:0] row,
                                                   input logic [2:0] i,
                                                   input logic flipx);
        logic [2:0] nib;
        nib = flipx ? i : 3'd7 - i;
        return row[{nib, 2'b00} +: DOT_W];
    endfunction

endpackage

// File: rtl/scn_layer_fetch_if.sv
// rtl/scn_layer_fetch_if.sv - tilemap RAM req/ack and graphics ROM toggle handshake bundle
interface scn_layer_fetch_if;
    import scn_pkg::*;

    logic              ram_req;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_ack;
    logic [RAM_DW-1:0] ram_data;
    logic              rom_req;
    logic [ROM_AW-1:0] rom_address;
    logic              rom_ack;
    logic [ROM_DW-1:0] rom_data;

    modport master (
        output ram_req, ram_addr, rom_req, rom_address,
        input  ram_ack, ram_data, rom_ack, rom_data
    );

    modport slave (
        input  ram_req, ram_addr, rom_req, rom_address,
        output ram_ack, ram_data, rom_ack, rom_data
    );

endinterface

// File: rtl/scn_line_buffer.sv
// rtl/scn_line_buffer.sv - double-buffered line store with clear-on-swap via valid and parity tags
module scn_line_buffer
    import scn_pkg::*;
#(
    parameter int LINE_W = 320
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             swap_i,
    input  logic             fill_i,
    input  logic             we_i,
    input  logic [8:0]       waddr_i,
    input  logic [PIX_W-1:0] wdata_i,
    input  logic [8:0]       raddr_i,
    output logic [PIX_W-1:0] rdata_o
);

    logic [PIX_W:0] mem_q [0:1023];
    logic           sel_q;
    logic [1:0]     valid_q;
    logic [1:0]     par_q;
    logic [PIX_W:0] rd_q;
    logic           rvalid_q;
    logic           rpar_q;

    // sel_q names the display half; the other half is being filled.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q    <= 1'b0;
            valid_q  <= 2'b00;
            par_q    <= 2'b00;
            rvalid_q <= 1'b0;
            rpar_q   <= 1'b0;
        end else begin
            rvalid_q <= valid_q[sel_q] && ({1'b0, raddr_i} < 10'(LINE_W));
            rpar_q   <= par_q[sel_q];
            if (swap_i) begin
                sel_q          <= ~sel_q;
                valid_q[sel_q] <= fill_i;
                if (fill_i) begin
                    par_q[sel_q] <= ~par_q[sel_q];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[{~sel_q, waddr_i}] <= {par_q[~sel_q], wdata_i};
        end
        rd_q <= mem_q[{sel_q, raddr_i}];
    end

    // Entries whose tag misses the current parity belong to an older line and read as 0.
    assign rdata_o = (rvalid_q && (rd_q[PIX_W] == rpar_q)) ? rd_q[PIX_W-1:0] : '0;

endmodule

// File: rtl/scn_layer_fetch.sv
// rtl/scn_layer_fetch.sv - per-scanline tilemap layer fetch into a double line buffer
module scn_layer_fetch
    import scn_pkg::*;
#(
    parameter int          LINE_W         = 320,
    parameter int          MAP_COLS_LOG2  = 6,
    parameter int          MAP_ROWS_LOG2  = 6,
    parameter logic [15:0] MAP_BASE       = 16'h0000,
    parameter logic [15:0] ROWSCROLL_BASE = 16'h6000,
    parameter int          ROWSCROLL_EN   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                line_start,
    input  logic [8:0]          vcnt,
    input  logic                enable,
    input  logic [8:0]          scroll_x,
    input  logic [8:0]          scroll_y,
    scn_layer_fetch_if.master   mem,
    input  logic [8:0]          pix_x,
    output logic [PIX_W-1:0]    pix_out,
    output logic                busy,
    output logic                line_done,
    output logic                overrun
);

    localparam int          NTILES   = (LINE_W + TILE_W - 1) / TILE_W;
    localparam logic [15:0] COL_MASK = 16'((1 << MAP_COLS_LOG2) - 1);
    localparam logic [15:0] ROW_MASK = 16'((1 << MAP_ROWS_LOG2) - 1);

    scn_state_e  state_q, state_d;
    logic [6:0]  t_q, t_d;
    logic [2:0]  i_q, i_d;
    logic [8:0]  h_q, h_d;
    logic [8:0]  v_q, v_d;
    logic [7:0]  vline_q, vline_d;
    logic [7:0]  color_q, color_d;
    logic        flipx_q, flipx_d;
    logic        flipy_q, flipy_d;
    logic [15:0] code_q, code_d;
    logic [31:0] rom_data_q, rom_data_d;
    logic        ram_req_q, ram_req_d;
    logic [15:0] ram_addr_q, ram_addr_d;
    logic        rom_req_q, rom_req_d;
    logic [20:0] rom_addr_q, rom_addr_d;
    logic        rom_pend_q, rom_pend_d;
    logic        overrun_q;

    logic [15:0]        row_idx, col_idx, attr_addr;
    logic [2:0]         rom_row;
    logic signed [11:0] xs;
    logic               x_ok, we, fill;

    assign row_idx   = 16'(v_q[8:3]) & ROW_MASK;
    assign col_idx   = (16'(h_q[8:3]) + 16'(t_q)) & COL_MASK;
    assign attr_addr = MAP_BASE + 16'(((row_idx << MAP_COLS_LOG2) | col_idx) << 1);
    assign rom_row   = flipy_q ? ~v_q[2:0] : v_q[2:0];
    // Screen x of dot i in tile t, shifted left by the fine horizontal scroll.
    assign xs        = $signed({2'b00, t_q, i_q}) - $signed({9'd0, h_q[2:0]});
    assign x_ok      = !xs[11] && (xs[10:0] < 11'(LINE_W));

    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        i_d        = i_q;
        h_d        = h_q;
        v_d        = v_q;
        vline_d    = vline_q;
        color_d    = color_q;
        flipx_d    = flipx_q;
        flipy_d    = flipy_q;
        code_d     = code_q;
        rom_data_d = rom_data_q;
        ram_req_d  = ram_req_q;
        ram_addr_d = ram_addr_q;
        rom_req_d  = rom_req_q;
        rom_addr_d = rom_addr_q;
        rom_pend_d = rom_pend_q;
        we         = 1'b0;
        fill       = 1'b0;

        case (state_q)
            ST_ROWSCROLL: begin
                if (!ram_req_q) begin
                    ram_req_d  = 1'b1;
                    ram_addr_d = ROWSCROLL_BASE + 16'(vline_q);
                end else if (mem.ram_ack) begin
                    ram_req_d = 1'b0;
                    h_d       = h_q + mem.ram_data[8:0];
                    state_d   = ST_ATTR;
                end
            end
            ST_ATTR: begin
                if (!ram_req_q) begin
                    ram_req_d  = 1'b1;
                    ram_addr_d = attr_addr;
                end else if (mem.ram_ack) begin
                    ram_req_d = 1'b0;
                    color_d   = mem.ram_data[COLOR_MSB:0];
                    flipx_d   = mem.ram_data[FLIPX_BIT];
                    flipy_d   = mem.ram_data[FLIPY_BIT];
                    state_d   = ST_CODE;
                end
            end
            ST_CODE: begin
                if (!ram_req_q) begin
                    ram_req_d  = 1'b1;
                    ram_addr_d = attr_addr + 16'd1;
                end else if (mem.ram_ack) begin
                    ram_req_d = 1'b0;
                    code_d    = mem.ram_data;
                    state_d   = ST_ROM;
                end
            end
            ST_ROM: begin
                // A toggle left over from an abandoned line must complete before a new one.
                if (!rom_pend_q) begin
                    if (mem.rom_ack == rom_req_q) begin
                        rom_req_d  = ~rom_req_q;
                        rom_addr_d = {code_q, rom_row, 2'b00};
                        rom_pend_d = 1'b1;
                    end
                end else if (mem.rom_ack == rom_req_q) begin
                    rom_pend_d = 1'b0;
                    rom_data_d = mem.rom_data;
                    i_d        = 3'd0;
                    state_d    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                we  = x_ok;
                i_d = i_q + 3'd1;
                if (i_q == 3'd7) begin
                    if (t_q == 7'(NTILES)) begin
                        state_d = ST_DONE;
                    end else begin
                        t_d     = t_q + 7'd1;
                        state_d = ST_ATTR;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (line_start) begin
            ram_req_d  = 1'b0;
            rom_pend_d = 1'b0;
            we         = 1'b0;
            t_d        = 7'd0;
            i_d        = 3'd0;
            vline_d    = vcnt[7:0];
            v_d        = vcnt + scroll_y;
            h_d        = scroll_x;
            fill       = enable;
            if (!enable) begin
                state_d = ST_IDLE;
            end else if (ROWSCROLL_EN != 0) begin
                state_d = ST_ROWSCROLL;
            end else begin
                state_d = ST_ATTR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            t_q        <= '0;
            i_q        <= '0;
            h_q        <= '0;
            v_q        <= '0;
            vline_q    <= '0;
            color_q    <= '0;
            flipx_q    <= 1'b0;
            flipy_q    <= 1'b0;
            code_q     <= '0;
            rom_data_q <= '0;
            ram_req_q  <= 1'b0;
            ram_addr_q <= '0;
            rom_req_q  <= 1'b0;
            rom_addr_q <= '0;
            rom_pend_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            i_q        <= i_d;
            h_q        <= h_d;
            v_q        <= v_d;
            vline_q    <= vline_d;
            color_q    <= color_d;
            flipx_q    <= flipx_d;
            flipy_q    <= flipy_d;
            code_q     <= code_d;
            rom_data_q <= rom_data_d;
            ram_req_q  <= ram_req_d;
            ram_addr_q <= ram_addr_d;
            rom_req_q  <= rom_req_d;
            rom_addr_q <= rom_addr_d;
            rom_pend_q <= rom_pend_d;
            overrun_q  <= line_start && busy;
        end
    end

    assign busy            = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign line_done       = (state_q == ST_DONE);
    assign overrun         = overrun_q;
    assign mem.ram_req     = ram_req_q;
    assign mem.ram_addr    = ram_addr_q;
    assign mem.rom_req     = rom_req_q;
    assign mem.rom_address = rom_addr_q;

    scn_line_buffer #(.LINE_W(LINE_W)) u_line_buffer (
        .clk     (clk),
        .reset   (reset),
        .swap_i  (line_start),
        .fill_i  (fill),
        .we_i    (we),
        .waddr_i (xs[8:0]),
        .wdata_i ({color_q, tile_dot(rom_data_q, i_q, flipx_q)}),
        .raddr_i (pix_x),
        .rdata_o (pix_out)
    );

endmodule

// File: tb/tb_scn_layer_fetch.sv
// tb/tb_scn_layer_fetch.sv - scoreboard bench for scn_layer_fetch with RAM and ROM responders
module tb_scn_layer_fetch;
    import scn_pkg::*;

    localparam int LW = 320;
    localparam int NT = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        line_start;
    logic [8:0]  vcnt;
    logic        enable;
    logic [8:0]  scroll_x;
    logic [8:0]  scroll_y;
    logic [8:0]  pix_x;
    logic [11:0] pix_out;
    logic        busy;
    logic        line_done;
    logic        overrun;

    always #5 clk = ~clk;

    scn_layer_fetch_if mem_if ();

    scn_layer_fetch #(.LINE_W(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .line_start (line_start),
        .vcnt       (vcnt),
        .enable     (enable),
        .scroll_x   (scroll_x),
        .scroll_y   (scroll_y),
        .mem        (mem_if),
        .pix_x      (pix_x),
        .pix_out    (pix_out),
        .busy       (busy),
        .line_done  (line_done),
        .overrun    (overrun)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [15:0] ram [0:65535];
    logic [20:0] rom_obs [$];
    logic        rom_stall;
    int          ram_req_cycles = 0;
    int          done_pulses = 0;

    function automatic logic [31:0] rom_fn(input logic [20:0] a);
        logic [20:0] d;
        d = a ^ 21'h000200;
        return 32'h12345678 ^ {d[12:2], d[20:13], d[12:0]};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mem_if.ram_ack <= 1'b0;
            mem_if.rom_ack <= 1'b0;
        end else begin
            mem_if.ram_ack  <= mem_if.ram_req && !mem_if.ram_ack;
            mem_if.ram_data <= ram[mem_if.ram_addr];
            if (!rom_stall && (mem_if.rom_req != mem_if.rom_ack)) begin
                mem_if.rom_ack  <= mem_if.rom_req;
                mem_if.rom_data <= rom_fn(mem_if.rom_address);
                rom_obs.push_back(mem_if.rom_address);
            end
        end
        if (mem_if.ram_req) ram_req_cycles++;
        if (line_done) done_pulses++;
    end

    // Screen x maps to map pixel (h + x) mod 512.
    function automatic logic [11:0] exp_pix(input logic [8:0] vc, input logic [8:0] sx,
                                            input logic [8:0] sy, input int x);
        logic [15:0] rs, attr, code;
        logic [8:0]  h, v, px;
        logic [2:0]  fy, r, k;
        logic [31:0] w;
        int          ai, kk;
        rs   = ram[16'h6000 + 16'(vc[7:0])];
        h    = sx + rs[8:0];
        v    = vc + sy;
        px   = h + 9'(x);
        ai   = {v[8:3], px[8:3]} * 2;
        attr = ram[ai];
        code = ram[ai + 1];
        fy   = v[2:0];
        r    = attr[15] ? 3'd7 - fy : fy;
        w    = rom_fn({code, r, 2'b00});
        k    = attr[14] ? 3'd7 - px[2:0] : px[2:0];
        kk   = int'(k);
        return {attr[7:0], 4'(w >> (28 - 4 * kk))};
    endfunction

    logic [11:0] sb [$];
    logic [11:0] got_line [0:LW+3];

    task automatic start_line(input logic [8:0] vc, input logic [8:0] sx,
                              input logic [8:0] sy, input logic en);
        @(negedge clk);
        vcnt = vc; scroll_x = sx; scroll_y = sy; enable = en; line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!line_done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, line_done, 1);
    endtask

    task automatic read_line(input string tag, input logic valid, input logic [8:0] vc,
                             input logic [8:0] sx, input logic [8:0] sy);
        start_line(9'd0, 9'd0, 9'd0, 1'b0);
        for (int x = 0; x < LW + 4; x++) begin
            pix_x = 9'(x);
            sb.push_back((valid && x < LW) ? exp_pix(vc, sx, sy, x) : 12'h000);
            @(negedge clk);
            got_line[x] = pix_out;
            check_eq($sformatf("%s px%0d", tag, x), pix_out, sb.pop_front());
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; line_start = 1'b0; vcnt = '0; enable = 1'b0;
        scroll_x = '0; scroll_y = '0; pix_x = '0; rom_stall = 1'b0;
        for (int a = 0; a < 65536; a++) ram[a] = 16'($urandom);
        ram[0] = 16'h0005; ram[1] = 16'h0010;
        ram[16'h6000] = 16'h0000; ram[16'h6001] = 16'h0000;
        repeat (3) @(negedge clk);
        check_eq("rst ram_req", mem_if.ram_req, 0);
        check_eq("rst rom_req", mem_if.rom_req, 0);
        check_eq("rst busy", busy, 0);
        check_eq("rst line_done", line_done, 0);
        check_eq("rst overrun", overrun, 0);
        check_eq("rst pix_out", pix_out, 0);
        reset = 1'b0;
        read_line("rst", 1'b0, 9'd0, 9'd0, 9'd0);

        rom_obs.delete();
        start_line(9'd0, 9'd0, 9'd0, 1'b1);
        check_eq("A busy", busy, 1);
        wait_done("A done");
        check_eq("A rom count", rom_obs.size(), NT + 1);
        check_eq("A rom addr0", rom_obs.size() > 0 ? rom_obs[0] : 21'h1fffff, 21'h000200);
        read_line("A", 1'b1, 9'd0, 9'd0, 9'd0);
        for (int i = 0; i < 8; i++) check_eq($sformatf("A fix%0d", i), got_line[i], 12'h051 + 12'(i));

        ram[0] = 16'h4005;
        start_line(9'd0, 9'd0, 9'd0, 1'b1);
        wait_done("B done");
        read_line("B", 1'b1, 9'd0, 9'd0, 9'd0);
        for (int i = 0; i < 8; i++) check_eq($sformatf("B fix%0d", i), got_line[i], 12'h058 - 12'(i));

        ram[0] = 16'h8005;
        rom_obs.delete();
        start_line(9'd1, 9'd0, 9'd0, 1'b1);
        wait_done("C done");
        check_eq("C rom addr0", rom_obs.size() > 0 ? rom_obs[0] : 21'h1fffff, 21'h000218);
        read_line("C", 1'b1, 9'd1, 9'd0, 9'd0);

        ram[0] = 16'h0005; ram[16'h6000] = 16'h0002;
        rom_obs.delete();
        start_line(9'd0, 9'd3, 9'd0, 1'b1);
        wait_done("D done");
        check_eq("D rom count", rom_obs.size(), NT + 1);
        read_line("D", 1'b1, 9'd0, 9'd3, 9'd0);
        check_eq("D fix0", got_line[0], 12'h056);
        check_eq("D fix2", got_line[2], 12'h058);

        n = ram_req_cycles;
        start_line(9'd5, 9'd0, 9'd0, 1'b0);
        n = ram_req_cycles - n;
        begin
            int d0, r0;
            d0 = done_pulses; r0 = ram_req_cycles;
            repeat (50) @(negedge clk);
            check_eq("E ram_req", ram_req_cycles - r0 + n, 0);
            check_eq("E line_done", done_pulses - d0, 0);
            check_eq("E busy", busy, 0);
        end
        read_line("E", 1'b0, 9'd5, 9'd0, 9'd0);

        rom_stall = 1'b1;
        start_line(9'd3, 9'd7, 9'd11, 1'b1);
        n = 0;
        while (mem_if.rom_req == mem_if.rom_ack && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("F rom pending", mem_if.rom_req != mem_if.rom_ack, 1);
        start_line(9'd4, 9'd100, 9'd37, 1'b1);
        check_eq("F overrun", overrun, 1);
        @(negedge clk);
        check_eq("F overrun pulse", overrun, 0);
        check_eq("F busy", busy, 1);
        repeat (20) @(negedge clk);
        rom_stall = 1'b0;
        wait_done("F done");
        read_line("F", 1'b1, 9'd4, 9'd100, 9'd37);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/scn_layer_fetch.md
# scn_layer_fetch

Parametrised, line-buffered tilemap layer engine; successor to the fixed-timing TC0100SCN BG/FG fetch. Per scanline it reads rowscroll, tile attribute and code words from tilemap RAM through a request/acknowledge port, fetches 8-pixel 4bpp rows from graphics ROM through the toggle handshake, and writes them into a double-buffered line buffer. The mixer reads the previously fetched line at any pixel rate. One instance per layer; map size, line width and addresses are parameters.

## Interface
- LINE_W, 320: visible pixels per line (8..512)
- MAP_COLS_LOG2, 6: log2 tilemap columns
- MAP_ROWS_LOG2, 6: log2 tilemap rows
- MAP_BASE, 16'h0000: RAM word address of tile (0,0) attribute
- ROWSCROLL_BASE, 16'h6000: RAM word address of rowscroll entry for line 0
- ROWSCROLL_EN, 1: 0 = skip rowscroll read, use 0
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- line_start  in  1  one-cycle pulse; swap buffers, begin fetch for `vcnt`
- vcnt  in  9  line being fetched (displayed next line)
- enable  in  1  sampled at line_start; 0 = line renders transparent
- scroll_x, scroll_y  in  9 each  layer scroll
- ram_req  out  1  level; held until ram_ack
- ram_addr  out  16  word address, stable while ram_req
- ram_ack  in  1  one-cycle pulse, ram_data valid same cycle
- ram_data  in  16  read data
- rom_req  out  1  toggles to request
- rom_address  out  21  {code, row[2:0], 2'b00}
- rom_ack  in  1  request complete when rom_ack == rom_req
- rom_data  in  32  valid when complete
- pix_x  in  9  read address into display buffer
- pix_out  out  12  {color[7:0], dot[3:0]}, one cycle after pix_x
- busy  out  1  fetch in progress
- line_done  out  1  one-cycle pulse, fetch finished
- overrun  out  1  one-cycle pulse, line_start while busy

## Operation
- Reset: ram_req, rom_req, busy, line_done, overrun, pix_out = 0; state IDLE; both buffers marked invalid (reads return 0).
- line_start: display/fetch buffers swap; fetch buffer marked invalid; if enable, enter ROWSCROLL (or ATTR if ROWSCROLL_EN=0) with tile t=0, else stay IDLE (new buffer stays invalid). Buffer becomes valid when fetch starts and unwritten positions are cleared to 0 (clear-on-swap via per-line valid bit plus per-pixel write-tag bit matching line parity).
- States: IDLE -> ROWSCROLL -> ATTR -> CODE -> ROM -> WRITE -> (ATTR for t+1 | DONE) -> IDLE.
- ROWSCROLL: read ROWSCROLL_BASE + vcnt[7:0]; h = scroll_x + rs[8:0] (mod 512).
- v = vcnt + scroll_y (mod 512); map row = v[8:3] mod 2^MAP_ROWS_LOG2; fine y = v[2:0].
- ATTR/CODE: col = (h[8:3] + t) mod 2^MAP_COLS_LOG2; attr at MAP_BASE + ((row<<MAP_COLS_LOG2)+col)*2, code at +1.
- attr[7:0] color, attr[14] flipx, attr[15] flipy; rom row = flipy ? 7-finey : finey.
- ROM: rom_address = {code, row, 2'b00}, toggle rom_req, wait rom_ack == rom_req.
- WRITE: 8 cycles, pixel i = rom_data[31-4k -: 4] with k = flipx ? 7-i : i; x = 8t + i - h[2:0]; written only if 0 <= x < LINE_W.
- Tiles fetched: t = 0 .. ceil(LINE_W/8) (one extra for fine scroll).
- line_start while busy: pulse overrun, abandon fetch (outstanding ram_req dropped; outstanding ROM toggle must still be absorbed: the next ROM request waits for rom_ack == rom_req first), swap, restart.
- Reset mid-fetch: immediate return to IDLE; rom_req returns to 0 only with rom_ack, the ROM side is reset with the same reset.

## Timing
- pix_out registered: pix_x at cycle n -> data at n+1; pix_x >= LINE_W returns 0.
- ram_addr/ram_req assert the cycle after state entry; data captured on ram_ack cycle.
- Minimum per tile: 2 RAM + 1 ROM round trip + 8 write cycles; line_done asserts the cycle after last write.
- Reads of display buffer and writes of fetch buffer never conflict (separate halves).

## Structure
- Package scn_pkg: state enum, attr field positions (COLOR_MSB, FLIPX_BIT, FLIPY_BIT), TILE_W = 8, DOT_W = 4.
- Sub-module scn_line_buffer: 2 x 512 x 13 simple dual-port RAM (12 data + tag), swap select, write port, registered read port.

## Test plan
- Reset, then pix_x = 0..319 -> pix_out = 0 throughout; ram_req = rom_req = 0.
- scroll 0, tile (0,0) attr 16'h0005 code 16'h0010, rom 32'h12345678 -> rom_address 21'h00200 at vcnt 0; next line pix 0..7 = 0x051..0x058.
- attr 16'h4005 (flipx) same data -> pix 0..7 = 0x058..0x051; attr 16'h8005, vcnt 1 -> rom_address row field 6.
- scroll_x = 3, rowscroll 16'h0002 -> h = 5, col 0 pixel 5 lands at x 0; last written pixel x = 319, none beyond.
- enable = 0 at line_start -> no ram_req, line_done not pulsed, next line all 0.
- Stall rom_ack, pulse line_start -> overrun = 1 one cycle, new fetch waits for stale ack then proceeds; line completes correctly.
